// File: rtl/game_pkg.sv
// Purpose: shared action codes, widths and the press priority encoder for the game core.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package game_pkg;

    localparam int ACT_W   = 3;
    localparam int LIVES_W = 2;
    localparam int NBTN    = 6;

    typedef logic [ACT_W-1:0] act_t;

    localparam act_t KICK  = 3'b000;
    localparam act_t PUNCH = 3'b001;
    localparam act_t SABR  = 3'b010;
    localparam act_t JUMP  = 3'b011;
    localparam act_t LEFT  = 3'b100;
    localparam act_t RIGHT = 3'b101;
    localparam act_t NONE  = 3'b111;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_HELD = 1'b1
    } latch_state_t;

    // Button index equals its action code, so the lowest set bit wins
    // (kick > punch > sabr > jump > left > right).
    function automatic act_t prio_code(input logic [NBTN-1:0] p);
        act_t c;
        c = NONE;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (p[i]) c = act_t'(i);
        end
        return c;
    endfunction

endpackage

// File: rtl/action_latch.sv
// Purpose: one player's button front-end: 2-flop sync, optional debounce, rise detect, priority latch.
// Latency: press to HELD in 3 clocks (3 + DEB_CYCLES when debounced); round_code is combinational.
// Backpressure: none; presses after the first in a round are dropped until the next tick.
//
// Ports: clk, reset (async active-low), btn[5:0] raw buttons, tick (round boundary),
//        hold_idle (forces IDLE, used after game over), round_code (code to issue at tick).
// Optional feature: ACTION_DEBOUNCE_EN inserts a per-button stability filter (parameter DEB_CYCLES).
module action_latch
    import game_pkg::*;
`ifdef ACTION_DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = 500_000
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn,
    input  logic            tick,
    input  logic            hold_idle,
    output act_t            round_code
);

    logic [NBTN-1:0] sync1, sync2;
    logic [NBTN-1:0] lvl;
    logic [NBTN-1:0] lvl_prev;
    logic [NBTN-1:0] press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef ACTION_DEBOUNCE_EN
    // The filtered level follows the synchronised level only after it has
    // disagreed for DEB_CYCLES consecutive clocks; any agreement restarts the wait.
    localparam int DW = $clog2(DEB_CYCLES);

    logic [NBTN-1:0] flt;
    logic [DW-1:0]   dcnt [NBTN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt <= '0;
            for (int i = 0; i < NBTN; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == flt[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
                    flt[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = flt;
`else
    assign lvl = sync2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lvl_prev <= '0;
        else        lvl_prev <= lvl;
    end

    assign press = lvl & ~lvl_prev;

    latch_state_t state_q, state_d;
    act_t         code_q, code_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= L_IDLE;
            code_q  <= NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (hold_idle) begin
            state_d = L_IDLE;
            code_d  = NONE;
        end else if (tick) begin
            // The current round's code leaves this cycle; a press seen in the
            // same cycle opens the next round instead of being lost.
            if (|press) begin
                state_d = L_HELD;
                code_d  = prio_code(press);
            end else begin
                state_d = L_IDLE;
                code_d  = NONE;
            end
        end else begin
            unique case (state_q)
                L_IDLE: begin
                    if (|press) begin
                        state_d = L_HELD;
                        code_d  = prio_code(press);
                    end
                end
                L_HELD: ;
                default: ;
            endcase
        end
    end

    // A held sabr button with nothing latched re-issues sabr every round.
    assign round_code = (state_q == L_HELD) ? code_q :
                        (lvl[SABR]         ? SABR   : NONE);

endmodule

// File: rtl/action_issuer.sv
// Purpose: round timer issuing one action per player with a one-clock control strobe; stops at game over.
// Latency: strobe every TICK_DIV clocks, first one TICK_DIV clocks after reset release; game_over 1 clock after zero lives.
// Backpressure: none; the core must consume each strobe, no further strobes after game_over.
//
// Ports: clk, reset (async active-low), btn1/btn2 raw buttons, lives1/lives2 from the core,
//        action1/action2 codes (valid while control=1, NONE otherwise), control strobe, game_over (sticky).
// Optional feature: ACTION_DEBOUNCE_EN enables button debouncing (parameter DEB_CYCLES).
module action_issuer
    import game_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000
`ifdef ACTION_DEBOUNCE_EN
   ,parameter int DEB_CYCLES = 500_000
`endif
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NBTN-1:0]    btn1,
    input  logic [NBTN-1:0]    btn2,
    input  logic [LIVES_W-1:0] lives1,
    input  logic [LIVES_W-1:0] lives2,
    output act_t               action1,
    output act_t               action2,
    output logic               control,
    output logic               game_over
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             lives_zero;
    logic             tick;
    act_t             code1, code2;

    assign lives_zero = (lives1 == '0) || (lives2 == '0);
    // Zero lives seen on the tick cycle suppresses that strobe as well.
    assign tick = (cnt == CNT_LAST) && !game_over && !lives_zero;

    action_latch
`ifdef ACTION_DEBOUNCE_EN
        #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_latch1 (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn1),
        .tick       (tick),
        .hold_idle  (game_over),
        .round_code (code1)
    );

    action_latch
`ifdef ACTION_DEBOUNCE_EN
        #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_latch2 (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn2),
        .tick       (tick),
        .hold_idle  (game_over),
        .round_code (code2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            control   <= 1'b0;
            action1   <= NONE;
            action2   <= NONE;
            game_over <= 1'b0;
        end else begin
            game_over <= game_over | lives_zero;
            if (!game_over) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            control <= tick;
            action1 <= tick ? code1 : NONE;
            action2 <= tick ? code2 : NONE;
        end
    end

endmodule
